// File: rtl/riscv_pkg.sv
// Shared types and defaults for the pipeline control logic.
// Holds the sequencer state encoding and the default mul/div latency.
package riscv_pkg;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } pipe_ctrl_state_t;

    localparam int MD_LATENCY_DEFAULT = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
// Once it reaches all-ones it holds there instead of wrapping.
module sat_counter #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    output logic [PERF_W-1:0] count
);

    // Count qualifying cycles, stopping at the top of the range
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= {PERF_W{1'b0}};
        end else if (inc && (count != {PERF_W{1'b1}})) begin
            count <= count + PERF_W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline register sequencer: merges memory wait, mul/div occupancy, branch redirect
// and load-use stall into per-stage enable/flush/bubble controls plus a stall counter.
module pipeline_controller
    import riscv_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
    parameter int PERF_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              LoadUseStall,
    input  logic              BranchTaken_EX,
    input  logic              MdOp_ID_EX,
    input  logic              MemReq_EX_MEM,
    input  logic              DMemReady,
    output logic              PCWriteEnable,
    output logic              WriteEnable_IF_ID,
    output logic              WriteEnable_ID_EX,
    output logic              WriteEnable_EX_MEM,
    output logic              WriteEnable_MEM_WB,
    output logic              Flush_IF_ID,
    output logic              Flush_ID_EX,
    output logic              Bubble_EX_MEM,
    output logic              MdStart,
    output logic              MdHold,
    output logic              MdDone,
    output logic [PERF_W-1:0] StallCycles
);

    localparam int CNT_W = $clog2(MD_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(MD_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

    pipe_ctrl_state_t state_r;
    pipe_ctrl_state_t nextState_s;
    logic [CNT_W-1:0] mdCount_r;
    logic [CNT_W-1:0] nextCount_s;
    logic             memWait_s;

    assign memWait_s = MemReq_EX_MEM & ~DMemReady;

    // Next-state and control decode; memory wait outranks everything so nothing advances
    always_comb begin
        nextState_s        = state_r;
        nextCount_s        = mdCount_r;
        PCWriteEnable      = 1'b1;
        WriteEnable_IF_ID  = 1'b1;
        WriteEnable_ID_EX  = 1'b1;
        WriteEnable_EX_MEM = 1'b1;
        WriteEnable_MEM_WB = 1'b1;
        Flush_IF_ID        = 1'b0;
        Flush_ID_EX        = 1'b0;
        Bubble_EX_MEM      = 1'b0;
        MdStart            = 1'b0;
        MdHold             = 1'b0;
        MdDone             = 1'b0;

        if (!rst_n) begin
            nextState_s        = RUN;
            nextCount_s        = CNT_ZERO;
            PCWriteEnable      = 1'b0;
            WriteEnable_IF_ID  = 1'b0;
            WriteEnable_ID_EX  = 1'b0;
            WriteEnable_EX_MEM = 1'b0;
            WriteEnable_MEM_WB = 1'b0;
            Flush_IF_ID        = 1'b1;
            Flush_ID_EX        = 1'b1;
            Bubble_EX_MEM      = 1'b1;
        end else if (memWait_s) begin
            PCWriteEnable      = 1'b0;
            WriteEnable_IF_ID  = 1'b0;
            WriteEnable_ID_EX  = 1'b0;
            WriteEnable_EX_MEM = 1'b0;
            WriteEnable_MEM_WB = 1'b0;
            MdHold             = (state_r == MD_BUSY);
        end else begin
            case (state_r)
                RUN: begin
                    if (MdOp_ID_EX) begin
                        // The mul/div and any branch share the EX slot, so the op wins
                        MdStart           = 1'b1;
                        nextCount_s       = CNT_START;
                        nextState_s       = MD_BUSY;
                        PCWriteEnable     = 1'b0;
                        WriteEnable_IF_ID = 1'b0;
                        WriteEnable_ID_EX = 1'b0;
                        Bubble_EX_MEM     = 1'b1;
                    end else if (BranchTaken_EX) begin
                        Flush_IF_ID = 1'b1;
                        Flush_ID_EX = 1'b1;
                    end else if (LoadUseStall) begin
                        PCWriteEnable     = 1'b0;
                        WriteEnable_IF_ID = 1'b0;
                        Flush_ID_EX       = 1'b1;
                    end else begin
                        nextState_s = RUN;
                    end
                end
                MD_BUSY: begin
                    if (mdCount_r != CNT_ZERO) begin
                        nextCount_s       = mdCount_r - CNT_W'(1);
                        PCWriteEnable     = 1'b0;
                        WriteEnable_IF_ID = 1'b0;
                        WriteEnable_ID_EX = 1'b0;
                        Bubble_EX_MEM     = 1'b1;
                    end else begin
                        MdDone      = 1'b1;
                        nextState_s = RUN;
                    end
                end
                default: begin
                    nextState_s        = RUN;
                    nextCount_s        = CNT_ZERO;
                    PCWriteEnable      = 1'b0;
                    WriteEnable_IF_ID  = 1'b0;
                    WriteEnable_ID_EX  = 1'b0;
                    WriteEnable_EX_MEM = 1'b0;
                    WriteEnable_MEM_WB = 1'b0;
                    Flush_IF_ID        = 1'b1;
                    Flush_ID_EX        = 1'b1;
                    Bubble_EX_MEM      = 1'b1;
                end
            endcase
        end
    end

    // Sequencer state and mul/div countdown
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= RUN;
            mdCount_r <= CNT_ZERO;
        end else begin
            state_r   <= nextState_s;
            mdCount_r <= nextCount_s;
        end
    end

    sat_counter #(
        .PERF_W(PERF_W)
    ) uStallCounter (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (~PCWriteEnable),
        .count(StallCycles)
    );

endmodule
